// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg -- shared definitions for the branch-prediction feedback path.
//
// Contents:
//   PC_W          default PC width used by the predictor and resolver
//   OPC_JAL/JALR  RISC-V opcodes of the unconditional jumps
//   pred_entry_t  one queued prediction: {pc, pred_pc}
//   br_state_t    resolver FSM states: RUN, FLUSH
// -----------------------------------------------------------------------------
package bp_pkg;

  localparam int PC_W = 48;

  localparam logic [6:0] OPC_JAL  = 7'h6f;
  localparam logic [6:0] OPC_JALR = 7'h67;

  typedef struct packed {
    logic [PC_W-1:0] pc;       // PC of the predicted control-flow instruction
    logic [PC_W-1:0] pred_pc;  // next PC fetch chose for it
  } pred_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } br_state_t;

endpackage

// File: rtl/pred_fifo.sv
// -----------------------------------------------------------------------------
// pred_fifo -- synchronous FIFO of in-flight predictions.
//
// Ports:
//   clk, n_reset  clock, asynchronous active-low reset
//   push, din     write din when push and not full
//   pop           drop the head entry when pop and not empty
//   clear         empty the FIFO; wins over push and pop in the same cycle
//   full, empty   occupancy flags (registered count, no bypass)
//   head          oldest entry; valid only while !empty
// -----------------------------------------------------------------------------
module pred_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = bp_pkg::pred_entry_t
) (
  input  logic clk,
  input  logic n_reset,
  input  logic push,
  input  logic pop,
  input  logic clear,
  input  T     din,
  output logic full,
  output logic empty,
  output T     head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;   // one bit wider than the pointers: full vs empty
  T              r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours, matching real hardware.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by r_count,
  // so stale contents are never observed and the RAM stays reset-free.
  always_ff @(posedge clk) begin
    if (w_push && !clear) r_mem[r_wr_ptr] <= din;
  end

  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/br_resolve.sv
// -----------------------------------------------------------------------------
// br_resolve -- execute-stage branch resolution unit.
//
// Queues every prediction fetch makes, compares each one in program order
// against the execute-stage outcome and, on a mismatch, redirects the
// predictor and holds the pipeline flushed for FLUSH_CYCLES cycles.
//
// Ports:
//   clk, n_reset                  clock, asynchronous active-low reset
//   enq_valid/ready, enq_pc,
//   enq_pred_pc                   prediction from fetch
//   res_valid/ready, res_pc,
//   res_target, res_taken         resolved outcome from execute
//   ext_flush                     exception/trap flush pulse
//   mispred                       one-cycle mispredict pulse
//   flush                         pipeline flush, high FLUSH_CYCLES cycles
//   correct_pc, index_pc          actual next PC / PC of last mispredict
//   sync_err                      one-cycle pulse: res_pc != queued pc
//   branch_cnt, mispred_cnt       saturating statistics
// -----------------------------------------------------------------------------
module br_resolve #(
  parameter int DEPTH        = 8,
  parameter int PC_W         = 48,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [PC_W-1:0]  enq_pc,
  input  logic [PC_W-1:0]  enq_pred_pc,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [PC_W-1:0]  res_pc,
  input  logic [PC_W-1:0]  res_target,
  input  logic             res_taken,
  input  logic             ext_flush,
  output logic             mispred,
  output logic             flush,
  output logic [PC_W-1:0]  correct_pc,
  output logic [PC_W-1:0]  index_pc,
  output logic             sync_err,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  import bp_pkg::*;

  // Same layout as pred_entry_t, sized to this instance's PC_W.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pred_pc;
  } entry_t;

  // The countdown holds "remaining flush cycles - 1".
  localparam int               FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0]  FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  br_state_t       r_state;
  br_state_t       w_state_nxt;
  logic [FC_W-1:0] r_flush_cnt;
  logic [FC_W-1:0] w_flush_cnt_nxt;

  logic            w_full;
  logic            w_empty;
  entry_t          w_head;
  entry_t          w_enq_entry;

  logic            w_enq_fire;
  logic            w_res_fire;
  logic [PC_W-1:0] w_actual;
  logic            w_pc_err;
  logic            w_tgt_err;
  logic            w_mis;
  logic            w_match;
  logic            w_clear;

  // ---------------------------------------------------------------------------
  // Prediction queue
  // ---------------------------------------------------------------------------
  assign w_enq_entry = '{pc: enq_pc, pred_pc: enq_pred_pc};

  pred_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push    (w_enq_fire),
    .pop     (w_match),
    .clear   (w_clear),
    .din     (w_enq_entry),
    .full    (w_full),
    .empty   (w_empty),
    .head    (w_head)
  );

  // ---------------------------------------------------------------------------
  // Compare against the head entry
  // ---------------------------------------------------------------------------
  assign w_enq_fire = enq_valid & enq_ready;
  assign w_res_fire = res_valid & res_ready;

  // Fall-through wraps modulo 2^PC_W.
  assign w_actual  = res_taken ? res_target : res_pc + PC_W'(4);
  assign w_pc_err  = (res_pc != w_head.pc);
  assign w_tgt_err = (w_actual != w_head.pred_pc);

  // ext_flush discards a resolution offered in the same cycle.
  assign w_mis   = w_res_fire & ~ext_flush & (w_pc_err | w_tgt_err);
  assign w_match = w_res_fire & ~ext_flush & ~(w_pc_err | w_tgt_err);
  assign w_clear = ext_flush | w_mis;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state     <= RUN;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  // FSM: next state. A mispredict or ext_flush (re)starts the countdown.
  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    case (r_state)
      RUN: begin
        if (w_clear) begin
          w_state_nxt     = FLUSH;
          w_flush_cnt_nxt = FC_LOAD;
        end
      end
      FLUSH: begin
        if (ext_flush) begin
          w_flush_cnt_nxt = FC_LOAD;
        end else if (r_flush_cnt == '0) begin
          w_state_nxt = RUN;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - FC_W'(1);
        end
      end
      default: begin
        w_state_nxt     = RUN;
        w_flush_cnt_nxt = '0;
      end
    endcase
  end

  // FSM: outputs. Handshakes close while flushing; full blocks enqueue even
  // if a pop happens in the same cycle.
  always_comb begin
    flush     = 1'b0;
    enq_ready = 1'b0;
    res_ready = 1'b0;
    case (r_state)
      RUN: begin
        enq_ready = ~w_full;
        res_ready = ~w_empty;
      end
      FLUSH:   flush = 1'b1;
      default: flush = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Redirect pulses, redirect PCs and statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mispred     <= 1'b0;
      sync_err    <= 1'b0;
      correct_pc  <= '0;
      index_pc    <= '0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      mispred  <= w_mis;
      sync_err <= w_mis & w_pc_err;
      if (w_mis) begin
        correct_pc <= w_actual;
        index_pc   <= res_pc;
      end
      if ((w_match || w_mis) && !(&branch_cnt)) branch_cnt  <= branch_cnt + CNT_W'(1);
      if (w_mis && !(&mispred_cnt))             mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_br_resolve.sv
// -----------------------------------------------------------------------------
// tb_br_resolve -- self-checking bench for br_resolve.
//
// A queue-based model tracks what the unit must hold; a compare process checks
// every DUT output against it each cycle. Directed sequences pin the model
// with literal values, then randomized traffic runs long enough to saturate
// the (deliberately narrow) statistics counters.
// -----------------------------------------------------------------------------
module tb_br_resolve;

  localparam int DEPTH        = 8;
  localparam int PC_W         = 48;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 6;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic             clk;
  logic             n_reset;
  logic             enq_valid;
  logic             enq_ready;
  logic [PC_W-1:0]  enq_pc;
  logic [PC_W-1:0]  enq_pred_pc;
  logic             res_valid;
  logic             res_ready;
  logic [PC_W-1:0]  res_pc;
  logic [PC_W-1:0]  res_target;
  logic             res_taken;
  logic             ext_flush;
  logic             mispred;
  logic             flush;
  logic [PC_W-1:0]  correct_pc;
  logic [PC_W-1:0]  index_pc;
  logic             sync_err;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  br_resolve #(
    .DEPTH        (DEPTH),
    .PC_W         (PC_W),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .enq_valid   (enq_valid),
    .enq_ready   (enq_ready),
    .enq_pc      (enq_pc),
    .enq_pred_pc (enq_pred_pc),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_pc      (res_pc),
    .res_target  (res_target),
    .res_taken   (res_taken),
    .ext_flush   (ext_flush),
    .mispred     (mispred),
    .flush       (flush),
    .correct_pc  (correct_pc),
    .index_pc    (index_pc),
    .sync_err    (sync_err),
    .branch_cnt  (branch_cnt),
    .mispred_cnt (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: in-flight predictions as a queue, flush as a number of
  // cycles still to go.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pred;
  } ent_t;

  ent_t            mq[$];
  int              m_flush_left = 0;
  bit              m_mispred    = 1'b0;
  bit              m_sync       = 1'b0;
  logic [PC_W-1:0] m_cpc        = '0;
  logic [PC_W-1:0] m_ipc        = '0;
  int              m_bc         = 0;
  int              m_mc         = 0;

  function automatic bit m_enq_ready();
    return (m_flush_left == 0) && (mq.size() < DEPTH);
  endfunction

  function automatic bit m_res_ready();
    return (m_flush_left == 0) && (mq.size() > 0);
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  always @(posedge clk or negedge n_reset) begin : model
    bit              en;
    bit              rf;
    logic [PC_W-1:0] act;
    if (!n_reset) begin
      mq.delete();
      m_flush_left = 0;
      m_mispred    = 1'b0;
      m_sync       = 1'b0;
      m_cpc        = '0;
      m_ipc        = '0;
      m_bc         = 0;
      m_mc         = 0;
    end else begin
      en = enq_valid && m_enq_ready();
      rf = res_valid && m_res_ready();
      m_mispred = 1'b0;
      m_sync    = 1'b0;
      if (ext_flush) begin
        mq.delete();
        m_flush_left = FLUSH_CYCLES;
      end else begin
        if (m_flush_left > 0) m_flush_left--;
        if (rf) begin
          act  = res_taken ? res_target : res_pc + 48'd4;
          m_bc = sat_inc(m_bc);
          if (res_pc == mq[0].pc && act == mq[0].pred) begin
            void'(mq.pop_front());
          end else begin
            m_mispred    = 1'b1;
            m_sync       = (res_pc != mq[0].pc);
            m_cpc        = act;
            m_ipc        = res_pc;
            m_mc         = sat_inc(m_mc);
            mq.delete();
            m_flush_left = FLUSH_CYCLES;
            en           = 1'b0;
          end
        end
        if (en) mq.push_back('{pc: enq_pc, pred: enq_pred_pc});
      end
    end
  end

  // One compare process: every output, every cycle, mid-cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("enq_ready",   64'(enq_ready),   64'(m_enq_ready()));
      check("res_ready",   64'(res_ready),   64'(m_res_ready()));
      check("flush",       64'(flush),       64'(m_flush_left > 0));
      check("mispred",     64'(mispred),     64'(m_mispred));
      check("sync_err",    64'(sync_err),    64'(m_sync));
      check("correct_pc",  64'(correct_pc),  64'(m_cpc));
      check("index_pc",    64'(index_pc),    64'(m_ipc));
      check("branch_cnt",  64'(branch_cnt),  64'(m_bc));
      check("mispred_cnt", 64'(mispred_cnt), 64'(m_mc));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic cyc(input logic ev, input logic [PC_W-1:0] ep, input logic [PC_W-1:0] epp,
                     input logic rv, input logic [PC_W-1:0] rp, input logic [PC_W-1:0] rt,
                     input logic rtk, input logic ef);
    enq_valid   = ev;
    enq_pc      = ep;
    enq_pred_pc = epp;
    res_valid   = rv;
    res_pc      = rp;
    res_target  = rt;
    res_taken   = rtk;
    ext_flush   = ef;
    @(posedge clk);
    #1;
    enq_valid = 1'b0;
    res_valid = 1'b0;
    ext_flush = 1'b0;
  endtask

  task automatic enq(input logic [PC_W-1:0] p, input logic [PC_W-1:0] q);
    cyc(1'b1, p, q, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic res(input logic [PC_W-1:0] p, input logic [PC_W-1:0] t, input logic tk);
    cyc(1'b0, '0, '0, 1'b1, p, t, tk, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  function automatic logic [PC_W-1:0] rand_pc();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[PC_W-1:0];
  endfunction

  task automatic rand_cycle();
    logic            ev;
    logic            rv;
    logic            tk;
    logic            ef;
    logic [PC_W-1:0] ep;
    logic [PC_W-1:0] epp;
    logic [PC_W-1:0] rp;
    logic [PC_W-1:0] rt;
    ev  = ($urandom_range(0, 99) < 60);
    ep  = rand_pc();
    epp = ($urandom_range(0, 1) == 1) ? ep + 48'd4 : rand_pc();
    rv  = ($urandom_range(0, 99) < 60);
    rp  = rand_pc();
    rt  = rand_pc();
    tk  = 1'($urandom_range(0, 1));
    if (mq.size() > 0) begin
      if ($urandom_range(0, 99) < 70) begin
        rp = mq[0].pc;
        if (mq[0].pred == mq[0].pc + 48'd4 && $urandom_range(0, 1) == 1) begin
          tk = 1'b0;
        end else begin
          tk = 1'b1;
          rt = mq[0].pred;
        end
      end else if ($urandom_range(0, 1) == 1) begin
        rp = mq[0].pc;
      end
    end
    ef = ($urandom_range(0, 99) < 2);
    cyc(ev, ep, epp, rv, rp, rt, tk, ef);
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    n_reset     = 1'b0;
    enq_valid   = 1'b0;
    enq_pc      = '0;
    enq_pred_pc = '0;
    res_valid   = 1'b0;
    res_pc      = '0;
    res_target  = '0;
    res_taken   = 1'b0;
    ext_flush   = 1'b0;
    #2 cmp_en = 1'b1;
    #20 n_reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    check("reset enq_ready",  64'(enq_ready),   64'd1);
    check("reset res_ready",  64'(res_ready),   64'd0);
    check("reset flush",      64'(flush),       64'd0);
    check("reset correct_pc", 64'(correct_pc),  64'd0);
    check("reset branch_cnt", 64'(branch_cnt),  64'd0);

    // Correct prediction
    enq(48'h1000, 48'h1040);
    res(48'h1000, 48'h1040, 1'b1);
    check("good mispred",    64'(mispred),    64'd0);
    check("good branch_cnt", 64'(branch_cnt), 64'd1);
    check("good res_ready",  64'(res_ready),  64'd0);

    // Not-taken mispredict; flush held exactly two cycles
    enq(48'h2000, 48'h2100);
    res(48'h2000, 48'h0, 1'b0);
    check("nt mispred",     64'(mispred),     64'd1);
    check("nt correct_pc",  64'(correct_pc),  64'h2004);
    check("nt index_pc",    64'(index_pc),    64'h2000);
    check("nt flush c1",    64'(flush),       64'd1);
    check("nt enq_ready",   64'(enq_ready),   64'd0);
    check("nt mispred_cnt", 64'(mispred_cnt), 64'd1);
    idle(1);
    check("nt pulse end",   64'(mispred),     64'd0);
    check("nt flush c2",    64'(flush),       64'd1);
    idle(1);
    check("nt flush off",   64'(flush),       64'd0);
    check("nt enq back",    64'(enq_ready),   64'd1);

    // Full FIFO, blocked 9th offer with simultaneous pop, in-order resolution
    for (int i = 0; i < DEPTH; i++) enq(48'h4000 + 48'(16 * i), 48'h4040 + 48'(16 * i));
    check("full enq_ready", 64'(enq_ready), 64'd0);
    check("full res_ready", 64'(res_ready), 64'd1);
    cyc(1'b1, 48'h9000, 48'h9004, 1'b1, 48'h4000, 48'h4040, 1'b1, 1'b0);
    check("full pop enq_ready", 64'(enq_ready), 64'd1);
    for (int i = 1; i < DEPTH; i++) res(48'h4000 + 48'(16 * i), 48'h4040 + 48'(16 * i), 1'b1);
    check("order branch_cnt",  64'(branch_cnt),  64'd10);
    check("order mispred_cnt", 64'(mispred_cnt), 64'd1);
    check("order empty",       64'(res_ready),   64'd0);

    // Enqueue + mispredicting resolve with 3 queued: new entry dropped
    for (int i = 0; i < 3; i++) enq(48'h6000 + 48'(8 * i), 48'h6100 + 48'(8 * i));
    cyc(1'b1, 48'h7000, 48'h7004, 1'b1, 48'h6000, 48'h6500, 1'b1, 1'b0);
    check("simul mispred", 64'(mispred), 64'd1);
    idle(2);
    check("simul dropped",   64'(res_ready),   64'd0);
    check("simul enq_ready", 64'(enq_ready),   64'd1);
    check("simul counts",    64'(branch_cnt),  64'd11);

    // ext_flush together with a resolve: ext_flush wins
    enq(48'h5000, 48'h5004);
    cyc(1'b0, '0, '0, 1'b1, 48'h5000, 48'h0, 1'b0, 1'b1);
    check("xf mispred",     64'(mispred),     64'd0);
    check("xf flush",       64'(flush),       64'd1);
    check("xf branch_cnt",  64'(branch_cnt),  64'd11);
    check("xf mispred_cnt", 64'(mispred_cnt), 64'd2);
    check("xf correct_pc",  64'(correct_pc),  64'h6500);
    idle(2);
    check("xf flush off",   64'(flush),       64'd0);
    check("xf empty",       64'(res_ready),   64'd0);

    // Sync error: resolved pc differs from queued pc
    enq(48'h3004, 48'h3008);
    res(48'h3000, 48'h0, 1'b0);
    check("sync sync_err",   64'(sync_err),   64'd1);
    check("sync mispred",    64'(mispred),    64'd1);
    check("sync index_pc",   64'(index_pc),   64'h3000);
    check("sync correct_pc", 64'(correct_pc), 64'h3004);
    idle(1);
    check("sync pulse end",  64'(sync_err),   64'd0);
    idle(1);

    // Fall-through wraps at the top of the PC space
    enq(48'hFFFF_FFFF_FFFC, 48'h1234);
    res(48'hFFFF_FFFF_FFFC, 48'h0, 1'b0);
    check("wrap correct_pc",  64'(correct_pc),  64'h0);
    check("wrap index_pc",    64'(index_pc),    64'hFFFF_FFFF_FFFC);
    check("wrap mispred_cnt", 64'(mispred_cnt), 64'd4);
    idle(2);

    // Randomized traffic; long enough to saturate both counters
    for (int i = 0; i < 3000; i++) rand_cycle();
    idle(3);
    check("sat branch_cnt",  64'(branch_cnt),  64'(CNT_MAX));
    check("sat mispred_cnt", 64'(mispred_cnt), 64'(CNT_MAX));

    // Reset in the middle of a flush
    enq(48'h8000, 48'h8004);
    res(48'h8000, 48'h9000, 1'b1);
    check("rst pre flush", 64'(flush), 64'd1);
    #3 n_reset = 1'b0;
    #1;
    check("rst flush",      64'(flush),      64'd0);
    check("rst mispred",    64'(mispred),    64'd0);
    check("rst branch_cnt", 64'(branch_cnt), 64'd0);
    check("rst correct_pc", 64'(correct_pc), 64'd0);
    #2 n_reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst post flush",     64'(flush),     64'd0);
    check("rst post mispred",   64'(mispred),   64'd0);
    check("rst post enq_ready", 64'(enq_ready), 64'd1);
    idle(2);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/br_resolve.md
Name: br_resolve

Overview:
- Execute-stage branch resolution unit; the far end of the fetch predictor's feedback path.
- Queues every prediction fetch makes for a control-flow instruction (pc, predicted next pc).
- Compares each prediction, in program order, against the execute-stage outcome.
- On mismatch, drives mispred/correct_pc/index_pc/flush back to the fetch predictor and pipeline, then runs a timed flush sequence.

Parameters:
DEPTH, 8, number of in-flight predictions queued (power of two, >=2)
PC_W, 48, PC width in bits
FLUSH_CYCLES, 2, cycles flush is held after a mispredict or external flush (>=1)
CNT_W, 32, width of statistics counters

Ports:
clk  input  1  clock
n_reset  input  1  asynchronous active-low reset
enq_valid  input  1  fetch offers a prediction
enq_ready  output  1  prediction accepted when enq_valid & enq_ready
enq_pc  input  PC_W  PC of predicted control-flow instruction
enq_pred_pc  input  PC_W  predicted next PC
res_valid  input  1  execute offers a resolved branch
res_ready  output  1  resolution consumed when res_valid & res_ready
res_pc  input  PC_W  PC of resolved instruction
res_target  input  PC_W  computed target
res_taken  input  1  branch/jump taken
ext_flush  input  1  exception/trap flush request, single-cycle pulse
mispred  output  1  one-cycle mispredict pulse to predictor
flush  output  1  pipeline flush
correct_pc  output  PC_W  actual next PC of mispredicted instruction
index_pc  output  PC_W  PC of mispredicted instruction
sync_err  output  1  one-cycle pulse: res_pc != queued head pc
branch_cnt  output  CNT_W  resolved branches, saturating
mispred_cnt  output  CNT_W  mispredicts, saturating

Behaviour:
- Reset state:
  - FIFO empty; state RUN.
  - mispred, flush, sync_err = 0; correct_pc, index_pc, branch_cnt, mispred_cnt = 0.
- States:
  - RUN: normal operation.
  - FLUSH: countdown of FLUSH_CYCLES.
- Handshakes:
  - enq_ready = (state==RUN) & !full.
  - res_ready = (state==RUN) & !empty.
  - No enqueue-to-resolve bypass: an entry is resolvable the cycle after it is written.
- Actual next pc = res_taken ? res_target : res_pc + 4, truncated to PC_W (wraps mod 2^PC_W).
- Resolve fire, compared against FIFO head:
  - Match: actual == head.pred_pc and res_pc == head.pc. Pop head, branch_cnt++, no other output change.
  - Mismatch: actual != head.pred_pc, or res_pc != head.pc.
    - Next cycle: mispred=1 for one cycle; flush=1; correct_pc=actual; index_pc=res_pc.
    - sync_err=1 for one cycle if the pc differed.
    - branch_cnt++ and mispred_cnt++.
    - FIFO cleared; state -> FLUSH.
- FLUSH:
  - flush held for exactly FLUSH_CYCLES cycles, counted from the first cycle flush is high.
  - enq_ready=0, res_ready=0; then return to RUN with flush=0.
- correct_pc and index_pc hold their last value until the next mispredict.
- ext_flush (any state):
  - Clears FIFO; restarts the FLUSH countdown, so flush goes high next cycle for FLUSH_CYCLES.
  - No mispred pulse, no counter change.
- Simultaneous events:
  - enq fire + matching res fire: both occur; occupancy unchanged.
  - enq fire + mismatching res fire: the new entry is discarded (clear wins).
  - ext_flush + res fire: ext_flush wins; resolution discarded, counters unchanged, mispred not raised.
  - res_ready is 0 whenever empty or in FLUSH, so a res fire cannot coincide with these states.
  - Full: enq_ready=0 even if a pop occurs the same cycle.
- Pointers wrap modulo DEPTH; a separate count of width clog2(DEPTH)+1 distinguishes full from empty.
- Counters saturate at all-ones. If both increment in one cycle, each saturates independently.
- Reset mid-flush or with occupied FIFO: everything returns to reset state asynchronously. No stale flush or mispred after n_reset deasserts.

Decomposition:
- Shared package bp_pkg holds:
  - PC_W default.
  - Opcode constants OPC_JAL=7'h6f, OPC_JALR=7'h67.
  - typedef pred_entry_t (packed: pc, pred_pc).
  - typedef enum br_state_t {RUN, FLUSH}.
- Sub-module pred_fifo: parameterized synchronous FIFO of pred_entry_t.
  - Inputs: push, pop, clear; outputs: full, empty, head.
  - clear has priority over push and pop.
- br_resolve holds the compare logic, FSM, flush counter and statistics counters.

Test Plan:
- Correct prediction:
  - Stimulus: enq pc=0x1000, pred=0x1040; then res pc=0x1000, target=0x1040, taken=1.
  - Response: no mispred, branch_cnt=1, FIFO empty, res_ready=0.
- Not-taken mispredict:
  - Stimulus: enq pc=0x2000, pred=0x2100; res pc=0x2000, taken=0.
  - Response, next cycle: mispred pulse, correct_pc=0x2004, index_pc=0x2000.
  - flush high exactly 2 cycles; enq_ready=0 during flush; mispred_cnt=1.
- Full FIFO:
  - Stimulus: enqueue 8 entries with no resolves.
  - Response: enq_ready=0 on the 9th offer. After one matching resolve, enq_ready=1 the following cycle.
  - In-order check: entries resolve correctly in order 0..7.
- Simultaneous enq + mispredicting res with 3 entries queued:
  - Response: FIFO empty after the event, the new entry is dropped, and the next res_ready=0 until a new enqueue.
- ext_flush + res fire in the same cycle:
  - Response: no mispred, counters unchanged, flush 2 cycles, FIFO empty.
- Edge cases:
  - Sync error: res pc=0x3000 against head pc=0x3004 gives sync_err=1 and mispred=1.
  - Wrap: res_pc=0xFFFF_FFFF_FFFC, not taken, gives actual=0x0.
  - Reset mid-flush: asserting n_reset clears flush immediately.
